// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs every four bytes into a 32-bit word and presents
// it with a running word address over a valid/ready handshake.
module uart_word_rx #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int ADDR_W           = 16,
    parameter int BIG_ENDIAN       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic [31:0]       word_data,
    output logic [ADDR_W-1:0] word_addr,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    // state | meaning
    // IDLE  | waiting for falling edge on rxd_s
    // START | mid-start-bit check, aborts on glitch
    // DATA  | sampling 8 data bits, LSB first
    // STOP  | sampling stop bit, accepts or flags the byte
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int             CNT_W = $clog2(2 * CLK_PER_HALF_BIT + 1);
    localparam logic [CNT_W-1:0] HB_M1 = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BT_M1 = CNT_W'(2 * CLK_PER_HALF_BIT - 1);

    logic              rxd_s1_q, rxd_s_q;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic              done_q, done_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_data_q, word_data_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic              word_valid_q, word_valid_d;
    logic [4:0]        lane_lsb;
    logic              accept;

    assign lane_lsb = (BIG_ENDIAN != 0) ? {~byte_cnt_q, 3'b000} : {byte_cnt_q, 3'b000};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        done_d      = 1'b0;
        frame_err_d = frame_err_q;
        case (state_q)
            S_IDLE: begin
                if (!rxd_s_q) begin
                    state_d = S_START;
                    cnt_d   = HB_M1;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rxd_s_q) begin
                        state_d   = S_DATA;
                        cnt_d     = BT_M1;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxd_s_q, shift_q[7:1]};
                    cnt_d   = BT_M1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (rxd_s_q) begin
                        word_d[lane_lsb +: 8] = shift_q;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        done_d     = (byte_cnt_q == 2'd3);
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    assign accept = word_valid_q & word_ready;

    // A word completing in the same cycle the previous one is taken gets the next address.
    always_comb begin
        addr_d       = accept ? addr_q + 1'b1 : addr_q;
        word_valid_d = accept ? 1'b0 : word_valid_q;
        word_data_d  = word_data_q;
        word_addr_d  = word_addr_q;
        overrun_d    = overrun_q;
        if (done_q) begin
            if (!word_valid_q || accept) begin
                word_data_d  = word_q;
                word_addr_d  = addr_d;
                word_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1_q     <= 1'b1;
            rxd_s_q      <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            addr_q       <= '0;
            word_data_q  <= '0;
            word_addr_q  <= '0;
            word_valid_q <= 1'b0;
        end else begin
            rxd_s1_q     <= rxd;
            rxd_s_q      <= rxd_s1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            addr_q       <= addr_d;
            word_data_q  <= word_data_d;
            word_addr_q  <= word_addr_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_data  = word_data_q;
    assign word_addr  = word_addr_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE) | (byte_cnt_q != 2'd0);
endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: three instances share rxd/rst and differ in
// byte order (a vs b) and address width (c).
module tb_uart_word_rx;
    localparam int HB  = 4;
    localparam int BIT = 2 * HB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic        ready_ab = 1'b1;
    logic        ready_c  = 1'b1;

    logic [31:0] data_a, data_b, data_c;
    logic [15:0] addr_a, addr_b;
    logic [1:0]  addr_c;
    logic        valid_a, valid_b, valid_c;
    logic        ferr_a, ferr_b, ferr_c;
    logic        ovr_a, ovr_b, ovr_c;
    logic        busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_word_rx #(.CLK_PER_HALF_BIT(HB), .ADDR_W(16), .BIG_ENDIAN(1)) u_a (
        .clk(clk), .rst(rst), .rxd(rxd), .word_data(data_a), .word_addr(addr_a),
        .word_valid(valid_a), .word_ready(ready_ab), .frame_err(ferr_a),
        .overrun(ovr_a), .busy(busy_a));
    uart_word_rx #(.CLK_PER_HALF_BIT(HB), .ADDR_W(16), .BIG_ENDIAN(0)) u_b (
        .clk(clk), .rst(rst), .rxd(rxd), .word_data(data_b), .word_addr(addr_b),
        .word_valid(valid_b), .word_ready(ready_ab), .frame_err(ferr_b),
        .overrun(ovr_b), .busy(busy_b));
    uart_word_rx #(.CLK_PER_HALF_BIT(HB), .ADDR_W(2), .BIG_ENDIAN(1)) u_c (
        .clk(clk), .rst(rst), .rxd(rxd), .word_data(data_c), .word_addr(addr_c),
        .word_valid(valid_c), .word_ready(ready_c), .frame_err(ferr_c),
        .overrun(ovr_c), .busy(busy_c));

    // Each call starts and ends 1 ns after a rising edge.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_cycles);
        rxd = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (stop_cycles) @(posedge clk);
        #1;
        rxd = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1, BIT);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ready_ab = 1'b1;
        ready_c  = 1'b1;
        idle(3);
        do_reset();
        checks++;
        if ({data_a, addr_a, valid_a, ferr_a, ovr_a, busy_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: data=%h addr=%h valid=%b ferr=%b ovr=%b busy=%b, required all 0",
                     data_a, addr_a, valid_a, ferr_a, ovr_a, busy_a);
        end
        checks++;
        if ({data_c, addr_c, valid_c, ferr_c, ovr_c, busy_c} !== '0) begin
            errors++;
            $display("FAIL reset_c: data=%h addr=%h valid=%b busy=%b, required all 0",
                     data_c, addr_c, valid_c, busy_c);
        end
    endtask

    task automatic test_big_endian();
        do_reset();
        send_byte(8'hDE, 1'b1, BIT);
        send_byte(8'hAD, 1'b1, BIT);
        send_byte(8'hBE, 1'b1, BIT);
        send_byte(8'hEF, 1'b1, BIT - 1);
        checks++;
        if (valid_a !== 1'b0) begin
            errors++;
            $display("FAIL be_early_valid: got %b, required 0 on stop-sample cycle", valid_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_a !== 1'b1 || data_a !== 32'hDEADBEEF || addr_a !== 16'd0) begin
            errors++;
            $display("FAIL be_word: valid=%b data=%h addr=%h, required 1 DEADBEEF 0000",
                     valid_a, data_a, addr_a);
        end
        checks++;
        if (valid_b !== 1'b1 || data_b !== 32'hEFBEADDE) begin
            errors++;
            $display("FAIL le_word: valid=%b data=%h, required 1 EFBEADDE", valid_b, data_b);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_a !== 1'b0 || ferr_a !== 1'b0 || ovr_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL be_after: valid=%b ferr=%b ovr=%b busy=%b, required 0 0 0 0",
                     valid_a, ferr_a, ovr_a, busy_a);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        ready_ab = 1'b0;
        send_word(32'h00010203);
        checks++;
        if (valid_a !== 1'b1 || data_a !== 32'h00010203 || addr_a !== 16'd0 || ovr_a !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: valid=%b data=%h addr=%h ovr=%b, required 1 00010203 0000 0",
                     valid_a, data_a, addr_a, ovr_a);
        end
        send_word(32'h04050607);
        checks++;
        if (valid_a !== 1'b1 || data_a !== 32'h00010203 || addr_a !== 16'd0 || ovr_a !== 1'b1) begin
            errors++;
            $display("FAIL ovr_held: valid=%b data=%h addr=%h ovr=%b, required 1 00010203 0000 1",
                     valid_a, data_a, addr_a, ovr_a);
        end
        ready_ab = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (valid_a !== 1'b0 || ovr_a !== 1'b1) begin
            errors++;
            $display("FAIL ovr_accept: valid=%b ovr=%b, required 0 1", valid_a, ovr_a);
        end
        send_word(32'h08090A0B);
        checks++;
        if (valid_a !== 1'b1 || data_a !== 32'h08090A0B || addr_a !== 16'd1) begin
            errors++;
            $display("FAIL ovr_next: valid=%b data=%h addr=%h, required 1 08090A0B 0001",
                     valid_a, data_a, addr_a);
        end
    endtask

    task automatic test_frame_err();
        do_reset();
        send_byte(8'h55, 1'b0, BIT);
        idle(2 * BIT);
        checks++;
        if (ferr_a !== 1'b1 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL ferr_flag: ferr=%b busy=%b valid=%b, required 1 0 0", ferr_a, busy_a, valid_a);
        end
        send_word(32'h11223344);
        checks++;
        if (valid_a !== 1'b1 || data_a !== 32'h11223344 || addr_a !== 16'd0 || ferr_a !== 1'b1) begin
            errors++;
            $display("FAIL ferr_word: valid=%b data=%h addr=%h ferr=%b, required 1 11223344 0000 1",
                     valid_a, data_a, addr_a, ferr_a);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rxd = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy: busy=%b, required 1 while checking start bit", busy_a);
        end
        idle(10);
        checks++;
        if (busy_a !== 1'b0 || ferr_a !== 1'b0 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: busy=%b ferr=%b valid=%b, required 0 0 0", busy_a, ferr_a, valid_a);
        end
        send_word(32'hCAFEF00D);
        checks++;
        if (valid_a !== 1'b1 || data_a !== 32'hCAFEF00D || addr_a !== 16'd0) begin
            errors++;
            $display("FAIL glitch_word: valid=%b data=%h addr=%h, required 1 CAFEF00D 0000",
                     valid_a, data_a, addr_a);
        end
    endtask

    task automatic test_addr_wrap();
        logic [1:0]  exp_addr;
        logic [31:0] w;
        do_reset();
        ready_c = 1'b1;
        exp_addr = 2'd0;
        for (int k = 0; k < 5; k++) begin
            w = 32'hA0B0C0D0 + 32'(k);
            send_word(w);
            checks++;
            if (valid_c !== 1'b1 || addr_c !== exp_addr || data_c !== w) begin
                errors++;
                $display("FAIL wrap_word%0d: valid=%b addr=%0d data=%h, required 1 %0d %h",
                         k, valid_c, addr_c, data_c, exp_addr, w);
            end
            exp_addr = exp_addr + 2'd1;
        end
        send_byte(8'h99, 1'b1, BIT);
        rxd = 1'b0;
        repeat (BIT + 3 * BIT) @(posedge clk);
        #1;
        do_reset();
        checks++;
        if ({data_c, addr_c, valid_c, ferr_c, ovr_c, busy_c} !== '0) begin
            errors++;
            $display("FAIL wrap_midreset: data=%h addr=%h valid=%b busy=%b, required all 0",
                     data_c, addr_c, valid_c, busy_c);
        end
        rxd = 1'b1;
        idle(3 * BIT);
        send_word(32'h12345678);
        checks++;
        if (valid_c !== 1'b1 || addr_c !== 2'd0 || data_c !== 32'h12345678) begin
            errors++;
            $display("FAIL wrap_after_reset: valid=%b addr=%0d data=%h, required 1 0 12345678",
                     valid_c, addr_c, data_c);
        end
    endtask

    initial begin
        test_reset();
        test_big_endian();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_addr_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
